rom_load_ctrl: RTL
==================

Name: rom_load_ctrl

Overview:
Sequences the HPS ioctl download stream into the arcade core. Routes index-0 bytes to the game ROM write port through a small elastic FIFO with valid/ready backpressure, index-1 bytes to the game-select register, and index-254 bytes to the 8-byte DIP bank. Owns the core reset: the core is held in reset during download, during FIFO drain, and for a fixed settle period afterwards. Sits between hps_io and the galaxian core in the top-level emu.

Parameters:
ADDR_W, 16, ROM address width forwarded to the core.
FIFO_DEPTH, 4, ROM write FIFO entries; power of two, minimum 2.
SETTLE_CYCLES, 256, core reset hold after drain; minimum 1.

Ports:
clk_sys  in  1  system clock (12 MHz).
reset_n  in  1  asynchronous active-low reset.
ioctl_download  in  1  download active.
ioctl_wr  in  1  single-cycle byte strobe.
ioctl_addr  in  25  byte address.
ioctl_dout  in  8  byte data.
ioctl_index  in  8  stream index.
ioctl_wait  out  1  backpressure to HPS.
ext_reset  in  1  user/menu reset request, level.
rom_valid  out  1  ROM write request.
rom_ready  in  1  ROM sink accepts when rom_valid & rom_ready.
rom_addr  out  ADDR_W  ROM write address.
rom_data  out  8  ROM write data.
mod_id  out  8  game-select byte.
dip_sw  out  64  DIP bank; byte k = dip_sw[8k+7:8k].
core_reset  out  1  active-high reset to core.
overflow  out  1  sticky: a ROM byte was dropped.

Behaviour:
- Reset values: ioctl_wait=0, rom_valid=0, rom_addr=0, rom_data=0, mod_id=0, dip_sw=all ones, core_reset=1, overflow=0, state=HOLD, settle counter=SETTLE_CYCLES-1, FIFO empty.
- States: LOAD, FLUSH, HOLD, RUN. core_reset=1 in every state except RUN.
- Any state with ioctl_download=1 goes to LOAD on the next edge. This includes RUN and mid-HOLD.
- LOAD with ioctl_download=0 goes to FLUSH.
- FLUSH goes to HOLD when the FIFO is empty and rom_valid=0. The settle counter reloads to SETTLE_CYCLES-1.
- HOLD decrements the counter and goes to RUN when the counter is 0 and ext_reset=0. ext_reset=1 in HOLD reloads the counter.
- RUN with ext_reset=1 goes to HOLD with the counter reloaded.
- RUN to core_reset=0: core_reset is registered and drops on the edge entering RUN. Total settle is SETTLE_CYCLES+1 cycles after drain.
- Byte routing (any state, on ioctl_wr=1):
  - index 0 with addr[24:ADDR_W]==0: pushed to the FIFO as {addr[ADDR_W-1:0], data}.
  - index 0 with higher address bits set: discarded silently.
  - index 1: mod_id <= data (last write wins).
  - index 254 with addr[24:3]==0: dip_sw byte addr[2:0] <= data. Otherwise ignored.
  - Other indices: ignored.
- FIFO: the head is presented on rom_valid/rom_addr/rom_data. The head is popped when rom_valid & rom_ready. Push and pop in the same cycle keep the count unchanged. A push while full with no pop is dropped and sets overflow. overflow clears only on reset_n or on a rising edge of ioctl_download.
- Latency: with the FIFO empty, a byte written at edge N gives rom_valid=1 after edge N+1 (one registered stage). rom_addr/rom_data hold stable while rom_valid=1 and rom_ready=0.
- ioctl_wait = registered (count >= FIFO_DEPTH-1). This leaves one slot of margin for the HPS one-cycle reaction.
- Wrap-around: FIFO pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally. No ROM address arithmetic is performed; addresses are passed through.

Decomposition:
- Package rom_load_pkg: state enum (LOAD, FLUSH, HOLD, RUN), index constants (IDX_ROM=0, IDX_MOD=1, IDX_DIP=254), DIP_BYTES=8.
- One sub-module, rom_wr_fifo (synchronous FIFO with count, full/empty, push/pop). Controller FSM, decode and DIP/mod registers stay in rom_load_ctrl.

Test Plan:
- Reset release with no download -> core_reset=1 for 257 cycles then 0; dip_sw=64'hFFFF_FFFF_FFFF_FFFF; mod_id=0.
- Download index 0, 4 bytes at addr 0..3 (data A0..A3), rom_ready=1 -> four rom_valid beats in order, addr 0..3, data A0..A3; core_reset stays 1 until drain+257.
- Index-0 burst of 6 bytes with rom_ready=0 -> ioctl_wait=1 after 3rd byte; bytes 5,6 dropped, overflow=1; raising rom_ready emits bytes 1..4 only.
- Index 254 addr 2 data 8'h5A, addr 9 data 8'h11 -> dip_sw[23:16]=8'h5A; rest unchanged all ones.
- Index 1 data 8'h0C then 8'h03 -> mod_id=8'h03.
- In RUN, ext_reset pulse 1 cycle -> core_reset=1 next cycle, held 257 cycles; ioctl_download rising mid-HOLD -> LOAD, overflow cleared.

Source files
------------

// File: rtl/rom_load_pkg.sv
// Shared types and constants for the ioctl download sequencer.
package rom_load_pkg;

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_FLUSH,
    ST_HOLD,
    ST_RUN
  } state_t;

  localparam logic [7:0] IDX_ROM = 8'd0;
  localparam logic [7:0] IDX_MOD = 8'd1;
  localparam logic [7:0] IDX_DIP = 8'd254;

  localparam int unsigned DIP_BYTES = 8;

endpackage

// File: rtl/rom_wr_fifo.sv
// Synchronous ROM write FIFO. Head is shown through a registered valid flag,
// so a fresh entry into an empty FIFO becomes visible one edge after its push.
module rom_wr_fifo #(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic                     head_valid,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     drop
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW:0]      wr_ptr;
  logic [PW:0]      rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign count     = wr_ptr - rd_ptr;
  assign empty     = (count == '0);
  assign full      = (count == FULL_CNT);
  assign do_pop    = pop & head_valid;
  assign do_push   = push & (~full | do_pop);
  assign drop      = push & ~do_push;
  assign head_data = mem[rd_ptr[PW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      head_valid <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr[PW-1:0]] <= push_data;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      // Valid tracks entries already stored before this edge, minus the one leaving now.
      head_valid <= (count > CW'(do_pop));
    end
  end

endmodule

// File: rtl/rom_load_ctrl.sv
// Routes the HPS ioctl stream to ROM/mod/DIP targets and sequences core reset
// around downloads.
module rom_load_ctrl
  import rom_load_pkg::*;
#(
  parameter int unsigned ADDR_W        = 16,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned SETTLE_CYCLES = 256
) (
  input  logic                    clk_sys,
  input  logic                    reset_n,
  input  logic                    ioctl_download,
  input  logic                    ioctl_wr,
  input  logic [24:0]             ioctl_addr,
  input  logic [7:0]              ioctl_dout,
  input  logic [7:0]              ioctl_index,
  output logic                    ioctl_wait,
  input  logic                    ext_reset,
  output logic                    rom_valid,
  input  logic                    rom_ready,
  output logic [ADDR_W-1:0]       rom_addr,
  output logic [7:0]              rom_data,
  output logic [7:0]              mod_id,
  output logic [8*DIP_BYTES-1:0]  dip_sw,
  output logic                    core_reset,
  output logic                    overflow
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned SW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] WAIT_LEVEL  = CW'(FIFO_DEPTH - 1);

  state_t                   state_q, state_d;
  logic [SW-1:0]            settle_q, settle_d;
  logic                     core_reset_q;
  logic                     download_q;
  logic                     overflow_q;
  logic                     wait_q;
  logic [7:0]               mod_q;
  logic [8*DIP_BYTES-1:0]   dip_q;

  logic                     rom_hit;
  logic                     mod_hit;
  logic                     dip_hit;
  logic                     fifo_empty;
  logic                     fifo_drop;
  logic [CW-1:0]            fifo_count;
  logic [ADDR_W+7:0]        fifo_head;

  assign rom_hit = ioctl_wr && (ioctl_index == IDX_ROM) && ((ioctl_addr >> ADDR_W) == '0);
  assign mod_hit = ioctl_wr && (ioctl_index == IDX_MOD);
  assign dip_hit = ioctl_wr && (ioctl_index == IDX_DIP) && (ioctl_addr[24:3] == '0);

  rom_wr_fifo #(
    .WIDTH (ADDR_W + 8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk_sys),
    .rst_n      (reset_n),
    .push       (rom_hit),
    .push_data  ({ioctl_addr[ADDR_W-1:0], ioctl_dout}),
    .pop        (rom_ready),
    .head_valid (rom_valid),
    .head_data  (fifo_head),
    .count      (fifo_count),
    .empty      (fifo_empty),
    .drop       (fifo_drop)
  );

  assign rom_addr   = fifo_head[ADDR_W+7:8];
  assign rom_data   = fifo_head[7:0];
  assign ioctl_wait = wait_q;
  assign mod_id     = mod_q;
  assign dip_sw     = dip_q;
  assign core_reset = core_reset_q;
  assign overflow   = overflow_q;

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    if (ioctl_download) begin
      state_d = ST_LOAD;
    end else begin
      case (state_q)
        ST_LOAD:  state_d = ST_FLUSH;
        ST_FLUSH: begin
          if (fifo_empty && !rom_valid) begin
            state_d  = ST_HOLD;
            settle_d = SETTLE_LOAD;
          end
        end
        ST_HOLD: begin
          if (ext_reset) begin
            settle_d = SETTLE_LOAD;
          end else if (settle_q == '0) begin
            state_d = ST_RUN;
          end else begin
            settle_d = settle_q - 1'b1;
          end
        end
        ST_RUN: begin
          if (ext_reset) begin
            state_d  = ST_HOLD;
            settle_d = SETTLE_LOAD;
          end
        end
        default:  state_d = ST_HOLD;
      endcase
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_HOLD;
      settle_q     <= SETTLE_LOAD;
      core_reset_q <= 1'b1;
      download_q   <= 1'b0;
      overflow_q   <= 1'b0;
      wait_q       <= 1'b0;
      mod_q        <= '0;
      dip_q        <= '1;
    end else begin
      state_q      <= state_d;
      settle_q     <= settle_d;
      core_reset_q <= (state_d != ST_RUN);
      download_q   <= ioctl_download;
      wait_q       <= (fifo_count >= WAIT_LEVEL);
      // A drop in the same cycle as a new download start still reports.
      if (fifo_drop) begin
        overflow_q <= 1'b1;
      end else if (ioctl_download && !download_q) begin
        overflow_q <= 1'b0;
      end
      if (mod_hit) begin
        mod_q <= ioctl_dout;
      end
      if (dip_hit) begin
        dip_q[{ioctl_addr[2:0], 3'b000} +: 8] <= ioctl_dout;
      end
    end
  end

endmodule
